// File: rtl/serial_pkg.sv
// Shared types and constants for the framed serial receiver.
package serial_pkg;

  // Receiver frame position: waiting for start, collecting data, expecting stop.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Bits needed to count 0..w-1; never less than one bit.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/shift_in_reg.sv
// WIDTH-bit serial-in shift register. With MSB_FIRST=0 new bits enter at the
// top and shift right, so the first bit received ends up in bit 0. With
// MSB_FIRST=1 new bits enter at the bottom and shift left.
module shift_in_reg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic             i_serial,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  // Shift one bit in per enabled cycle; synchronous clear.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_q <= '0;
    end else if (i_en) begin
      if (MSB_FIRST) r_q <= {r_q[WIDTH-2:0], i_serial};
      else           r_q <= {i_serial, r_q[WIDTH-1:1]};
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/serial_deserializer.sv
// Rebuilds parallel words from a start/stop framed serial stream that advances
// only on bit_valid strobes. Completed words land in a one-entry output buffer.
//
// Handshake: data_out/data_valid form a valid/ready source. A word transfers on
// any rising edge where data_valid && data_ready. While data_valid=1 and no
// transfer has happened, data_out holds. A new word committed while the buffer
// is full and not being drained is dropped and flagged with overrun.
module serial_deserializer
  import serial_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_valid,
  input  logic             serial_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             busy,
  output logic             frame_error,
  output logic             overrun,
  output state_t           dbg_state
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_bit_cnt;
  logic [WIDTH-1:0] w_shift_q;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_frame_error;
  logic             r_overrun;
  logic             w_shift_en;
  logic             w_cnt_clr;
  logic             w_commit;
  logic             w_stop_bad;
  logic             w_load;

  shift_in_reg #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_shift (
    .clk     (clk),
    .i_reset (reset),
    .i_en    (w_shift_en),
    .i_serial(serial_in),
    .o_q     (w_shift_q)
  );

  // Frame state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode; nothing moves without a bit strobe.
  always_comb begin
    w_next     = r_state;
    w_shift_en = 1'b0;
    w_cnt_clr  = 1'b0;
    w_commit   = 1'b0;
    w_stop_bad = 1'b0;
    if (bit_valid) begin
      case (r_state)
        IDLE: begin
          if (serial_in == START_BIT) begin
            w_next    = DATA;
            w_cnt_clr = 1'b1;
          end
        end
        DATA: begin
          w_shift_en = 1'b1;
          if (r_bit_cnt == LAST) w_next = STOP;
        end
        STOP: begin
          // A 0 here is a bad stop bit, not a fresh start bit.
          w_next = IDLE;
          if (serial_in == STOP_BIT) w_commit   = 1'b1;
          else                       w_stop_bad = 1'b1;
        end
        default: w_next = IDLE;
      endcase
    end
  end

  // Data bit counter; saturates at WIDTH-1 so it never leaves range.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bit_cnt <= '0;
    end else if (w_cnt_clr) begin
      r_bit_cnt <= '0;
    end else if (w_shift_en && (r_bit_cnt != LAST)) begin
      r_bit_cnt <= r_bit_cnt + 1'b1;
    end
  end

  // A commit loads the buffer if it is empty or being drained this cycle.
  assign w_load = w_commit && (!r_valid || data_ready);

  // Output buffer, handshake and one-cycle error pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data        <= '0;
      r_valid       <= 1'b0;
      r_frame_error <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_frame_error <= w_stop_bad;
      r_overrun     <= w_commit && !w_load;
      if (w_load) begin
        r_data  <= w_shift_q;
        r_valid <= 1'b1;
      end else if (r_valid && data_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data_out    = r_data;
  assign data_valid  = r_valid;
  assign frame_error = r_frame_error;
  assign overrun     = r_overrun;
  assign busy        = (r_state != IDLE);
  assign dbg_state   = r_state;

endmodule

// File: doc/serial_deserializer.md
# serial_deserializer

Receive-side counterpart of the team's 8-bit load/shift-right register, which emits its LSB first. This block rebuilds parallel words from that serial stream. It is framed with a start bit (0) and a stop bit (1), and advances only on a bit strobe. Completed words go into a one-entry output buffer with a valid/ready handshake, so the consumer (LED/HEX display logic or a downstream register) can stall.

## Interface
Parameters:
- WIDTH, 8: data bits per frame.
- MSB_FIRST, 0: 0 means the first data bit received lands in data_out[0]. 1 means it lands in data_out[WIDTH-1].

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
- clk, in, 1: the single clock; all state updates on its rising edge.
- reset, in, 1: synchronous, active-high reset.
- bit_valid, in, 1: strobe marking serial_in as a sampled bit this cycle.
- serial_in, in, 1: serial data, LSB first by default.
- data_out, out, WIDTH: buffered received word.
- data_valid, out, 1: data_out holds an unconsumed word.
- data_ready, in, 1: consumer accepts the word when data_valid && data_ready.
- busy, out, 1: the FSM is not in IDLE.
- frame_error, out, 1: one-cycle pulse when the stop bit is 0.
- overrun, out, 1: one-cycle pulse when a completed word is dropped.

## Operation
The FSM has three states: IDLE, DATA and STOP. Only cycles with bit_valid=1 advance it; other cycles hold all state.
- IDLE:
  - bit_valid && serial_in==0 is a start bit: go to DATA and set bit_cnt=0.
  - bit_valid && serial_in==1 is line idle: stay in IDLE.
- DATA:
  - Each strobe shifts serial_in into shift_reg. With MSB_FIRST=0 the bit enters at [WIDTH-1] and shifts right; with MSB_FIRST=1 it enters at [0] and shifts left.
  - bit_cnt increments each strobe. After the strobe where bit_cnt==WIDTH-1, go to STOP.
- STOP:
  - On a strobe with serial_in==1, commit shift_reg to the output buffer, then go to IDLE.
  - On a strobe with serial_in==0, pulse frame_error, discard the word, and go to IDLE. The 0 is not taken as a new start bit.
- Commit rules:
  - Buffer empty, or data_ready asserted the same cycle: load data_out and set data_valid=1.
  - Buffer full and data_ready=0: drop the new word, pulse overrun, and leave data_out/data_valid unchanged.
- Handshake:
  - data_valid && data_ready with no commit that cycle clears data_valid the next cycle.
  - data_out is stable while data_valid=1 and the transfer has not completed.
- Widths: bit_cnt is $clog2(WIDTH) bits and never exceeds WIDTH-1.

## Timing
- Reset values: state=IDLE, bit_cnt=0, shift_reg=0, data_out=0, data_valid=0, busy=0, frame_error=0, overrun=0.
- Reset asserted mid-frame aborts the frame and clears the buffer. No error pulse is raised.
- Latency: data_valid rises on the clock edge that samples the valid stop-bit strobe, i.e. it is visible in the cycle after that strobe.
- A frame takes WIDTH+2 strobes: start, WIDTH data bits, stop.
- frame_error and overrun are asserted for exactly one cycle, the cycle after the stop strobe.
- busy=1 from the cycle after the start strobe up to and including the cycle of the stop strobe.
- Back-to-back frames are supported: a start bit may arrive on the strobe immediately after a stop bit.
- Simultaneous commit and acceptance (data_ready=1 with a full buffer): the old word transfers, the new word loads, data_valid stays 1, and no overrun is raised.
- bit_valid held high on consecutive cycles is legal and gives one bit per clock.

## Structure
- Package serial_pkg holds:
  - the state enum {IDLE, DATA, STOP};
  - START_BIT=1'b0 and STOP_BIT=1'b1;
  - a count-width helper function.
- Sub-module shift_in_reg holds the WIDTH-bit register with enable, serial input and direction parameter; it is cleared by reset.
- The FSM, bit counter and output buffer live in serial_deserializer.

## Test plan
- Reset, then strobe 0, 1,0,1,0,0,1,0,1, 1 (LSB first) with data_ready=1 -> data_out=8'hA5 and data_valid pulses for 1 cycle; no frame_error or overrun.
- The same frame with MSB_FIRST=1 -> data_out=8'hA5 becomes 8'hA5 bit-reversed = 8'hA5; then send 8'h01 LSB-first -> data_out=8'h80.
- A frame ending with stop bit 0 -> frame_error pulses 1 cycle, data_valid stays 0, FSM returns to IDLE, and a following valid frame of 8'h3C is received correctly.
- Two frames 8'h11 then 8'h22 with data_ready=0 -> data_out stays 8'h11 and overrun pulses at the second stop; asserting data_ready then clears data_valid.
- Reset pulsed after 4 data bits -> busy=0 and data_valid=0; the next full frame of 8'hFF is received intact.
- bit_valid held high continuously for back-to-back frames 8'h00 and 8'hFF with data_ready=1 -> two commits exactly WIDTH+2 cycles apart, correct values.
